// File: rtl/opseq_pkg.sv
// Shared types and constants for the operand sequencer front end.
package opseq_pkg;

  localparam int unsigned Width = 4;

  // Most negative operand: has no positive counterpart in Width bits.
  localparam logic [Width-1:0] MinNeg = 4'b1000;

  typedef enum logic [1:0] {
    StWaitX = 2'd0,
    StWaitY = 2'd1,
    StReady = 2'd2
  } state_e;

  function automatic logic [Width-1:0] neg2c(input logic [Width-1:0] v);
    return ~v + 1'b1;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Raw button -> 2-flop synchroniser -> optional debounce -> one-cycle rising-edge pulse.
// Debounce is compiled in only when OPSEQ_DEBOUNCE_EN is defined.
module btn_conditioner #(
  parameter int unsigned DebounceCycles = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic pulse_o
);

  logic [1:0] sync_q;
  logic       level;
  logic       prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
    end
  end

`ifdef OPSEQ_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DebounceCycles + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            deb_q, deb_d;

  // Any cycle where the synchronised input agrees with the accepted level restarts the count.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == CntW'(DebounceCycles - 1)) begin
        deb_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign level = deb_q;
`else
  assign level = sync_q[1];
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level;
    end
  end

  assign pulse_o = level & ~prev_q;

endmodule

// File: rtl/operand_sequencer.sv
// Collects operand X then Y from shared switches, one per load press, for the adder.
// Build option OPSEQ_DEBOUNCE_EN adds button debounce inside btn_conditioner.
module operand_sequencer
  import opseq_pkg::*;
#(
  parameter int unsigned DebounceCycles = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] sw_i,
  input  logic             btn_load_i,
  input  logic             btn_clear_i,
  input  logic             sub_i,
  output logic [Width-1:0] x_out_o,
  output logic [Width-1:0] y_out_o,
  output logic             op_valid_o,
  output logic             neg_err_o,
  output logic [1:0]       state_out_o
);

  logic load_p, clear_p;

  btn_conditioner #(
    .DebounceCycles(DebounceCycles)
  ) u_load_cond (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .btn_i  (btn_load_i),
    .pulse_o(load_p)
  );

  btn_conditioner #(
    .DebounceCycles(DebounceCycles)
  ) u_clear_cond (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .btn_i  (btn_clear_i),
    .pulse_o(clear_p)
  );

  state_e           state_q, state_d;
  logic [Width-1:0] x_q, x_d, y_q, y_d;
  logic             valid_q, valid_d, err_q, err_d;

  // Clear has priority; any state other than WaitY (including the unused code) acts as WaitX.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (clear_p) begin
      state_d = StWaitX;
      x_d     = '0;
      y_d     = '0;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end else if (load_p) begin
      if (state_q == StWaitY) begin
        y_d = sub_i ? neg2c(sw_i) : sw_i;
        if (sub_i && (sw_i == MinNeg)) begin
          err_d = 1'b1;
        end
        valid_d = 1'b1;
        state_d = StReady;
      end else begin
        x_d     = sw_i;
        err_d   = 1'b0;
        valid_d = 1'b0;
        state_d = StWaitY;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StWaitX;
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign x_out_o     = x_q;
  assign y_out_o     = y_q;
  assign op_valid_o  = valid_q;
  assign neg_err_o   = err_q;
  assign state_out_o = state_q;

endmodule
